// File: rtl/led_sweep_ctrl.sv
// led_sweep_ctrl: knight-rider LED sweep sequencer with pass count and stop; define LED_SWEEP_CTRL_DWELL_EN for end dwell
module led_sweep_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4,
  parameter int DWELL    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [3:0]       speed_i,
  input  logic [3:0]       passes_i,
  output logic [WIDTH-1:0] leds_o,
  output logic             busy_o,
  output logic             dir_o,
  output logic             done_o
);
  localparam int CW  = $clog2(16 * PRESCALE);
  localparam int DWW = $clog2(DWELL + 1);
`ifdef LED_SWEEP_CTRL_DWELL_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LEFT, DWELL_L, RIGHT, DWELL_R} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, period_m1;
  logic [DWW-1:0] dwell_cnt;
  logic [3:0] speed_q, passes_q, pass_cnt;
  logic tick, dwell_last, last_pass;
  assign period_m1  = CW'((32'(speed_q) + 32'd1) * PRESCALE - 1);
  assign tick       = (state != IDLE) && (cnt == period_m1);
  assign dwell_last = dwell_cnt == DWW'(DWELL - 1);
  assign last_pass  = (passes_q != 4'd0) && (pass_cnt + 4'd1 == passes_q);
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  // one-hot position: bit WIDTH-2 set means the next left shift lands on the MSB
  always_comb begin
    state_n = state;
    if (stop_i) state_n = IDLE;
    else case (state)
      IDLE:    state_n = start_i ? LEFT : IDLE;
      LEFT:    state_n = (tick && leds_o[WIDTH-2]) ? (DWELL_EN ? DWELL_L : RIGHT) : LEFT;
      DWELL_L: state_n = (tick && dwell_last) ? RIGHT : DWELL_L;
      RIGHT:   state_n = (tick && leds_o[1]) ? (last_pass ? IDLE : (DWELL_EN ? DWELL_R : LEFT)) : RIGHT;
      DWELL_R: state_n = (tick && dwell_last) ? LEFT : DWELL_R;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy_o = state != IDLE;
    dir_o  = (state == DWELL_L) || (state == RIGHT);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      leds_o    <= '0;
      done_o    <= 1'b0;
      cnt       <= '0;
      dwell_cnt <= '0;
      speed_q   <= '0;
      passes_q  <= '0;
      pass_cnt  <= '0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        cnt       <= '0;
        dwell_cnt <= '0;
        if (start_i && !stop_i) begin
          speed_q  <= speed_i;
          passes_q <= passes_i;
          pass_cnt <= '0;
          leds_o   <= WIDTH'(1);
        end
      end else if (stop_i) begin
        leds_o <= '0;
        cnt    <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) case (state)
          LEFT:             leds_o <= leds_o << 1;
          DWELL_L, DWELL_R: dwell_cnt <= dwell_last ? '0 : dwell_cnt + 1'b1;
          RIGHT:
            if (leds_o[1]) begin
              pass_cnt <= pass_cnt + 4'd1;
              leds_o   <= last_pass ? '0 : WIDTH'(1);
              done_o   <= last_pass;
            end else leds_o <= leds_o >> 1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/led_sweep_ctrl.md
# led_sweep_ctrl

Sequencer for the board's 8-LED "knight rider" sweep. It owns step timing, sweep direction, the pass count and start/stop control, and drives a one-hot LED vector directly. It sits between the switch/button front-end (start, stop, speed and pass-count inputs) and the LED pins. It replaces free-running shifting with a controlled, countable, stoppable sequence.

## Interface
- `WIDTH`, 8: number of LEDs; must be ≥ 2.
- `PRESCALE`, 4: clock cycles per speed unit; must be ≥ 1.
- `DWELL`, 2: ticks the LED is held at each end. Used only with `LED_SWEEP_CTRL_DWELL_EN`; must be ≥ 1.
- `clk_i`  in  1: single clock; all state updates on the rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `start_i`  in  1: level, sampled each cycle; accepted only in IDLE.
- `stop_i`  in  1: abort request; takes priority over `start_i`.
- `speed_i`  in  4: step period = (speed_i+1)·PRESCALE cycles; captured at start.
- `passes_i`  in  4: number of full sweeps to run; 0 = run until stopped; captured at start.
- `leds_o`  out  WIDTH: one-hot LED position, or all zeros when idle.
- `busy_o`  out  1: high in every state except IDLE.
- `dir_o`  out  1: 0 = next move toward MSB; 1 = next move toward LSB.
- `done_o`  out  1: one-cycle pulse when the final pass completes.

## Operation
- Reset values: `leds_o`=0, `busy_o`=0, `dir_o`=0, `done_o`=0, state IDLE, all counters 0.
- States:
  - IDLE.
  - LEFT: shifting toward the MSB.
  - DWELL_L: held at the MSB.
  - RIGHT: shifting toward the LSB.
  - DWELL_R: held at the LSB.
- Tick counter `cnt`:
  - Runs only when not in IDLE and counts 0..P−1, where P = (speed_q+1)·PRESCALE.
  - `tick` is asserted while cnt = P−1; cnt returns to 0 on that edge.
  - Counter width is sized for 16·PRESCALE.
- IDLE + start_i + !stop_i:
  - Captures speed_q and passes_q; clears pass_cnt and cnt.
  - Sets leds_o = 1 (bit 0) and moves to LEFT.
- LEFT, on tick: leds_o <<= 1.
  - If the new value has bit WIDTH−1 set: go to DWELL_L if dwell is compiled in, otherwise to RIGHT.
- DWELL_L: after DWELL ticks, go to RIGHT with leds_o unchanged.
- RIGHT, on tick, with leds_o ≠ bit 1: leds_o >>= 1.
- RIGHT, on tick, with leds_o = bit 1 (completing a pass): pass_cnt increments.
  - Final pass (passes_q ≠ 0 and pass_cnt+1 = passes_q): go to IDLE, leds_o = 0, done_o = 1 for exactly one cycle.
  - Otherwise: leds_o = bit 0, then go to DWELL_R if dwell is compiled in, otherwise to LEFT.
- DWELL_R: after DWELL ticks, go to LEFT with leds_o unchanged.
- With passes_q = 0, pass_cnt wraps modulo 16 and has no effect.
- stop_i in any non-IDLE state: next edge goes to IDLE with leds_o = 0 and cnt = 0. No done_o pulse.
- stop_i and start_i together in IDLE: start is ignored.
- start_i while busy: ignored. Changes to speed_i or passes_i while busy: no effect.
- dir_o is 1 in DWELL_L and RIGHT, and 0 in every other state.
- rst_i mid-sweep: all outputs return to reset values on that edge, with no done_o pulse.

## Timing
- Start is accepted on edge E0, and leds_o = 1 from E0.
- The first shift occurs at E0+P; each later move or dwell step takes P cycles.
- One pass without dwell is 2·(WIDTH−1) ticks. With dwell it is 2·(WIDTH−1)+DWELL ticks; DWELL_R is entered only between passes.
- done_o rises on the same edge that returns leds_o to 0 and busy_o to 0.
- A new start can be accepted on the cycle after done_o.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `LED_SWEEP_CTRL_DWELL_EN` defined:
  - DWELL_L and DWELL_R exist.
  - The LED holds for DWELL ticks at the MSB on every pass, and at the LSB between passes.
- `LED_SWEEP_CTRL_DWELL_EN` undefined:
  - No dwell states; the DWELL parameter is ignored.
  - Direction reverses on the tick immediately after an end is reached.

## Test plan
- Reset check: hold rst_i for 3 cycles mid-sweep → leds_o=0, busy_o=0, dir_o=0, done_o=0; no done_o pulse.
- Basic pass, macro off, WIDTH=8, PRESCALE=1, speed_i=0, passes_i=1, start at E0 → leds_o steps 01,02,…,80 at E0..E7, then 40…02 at E8..E13. At E14: leds_o=00, done_o=1 for one cycle, busy_o=0.
- Dwell pass, macro on, DWELL=2, same stimulus → leds_o=80 held at E7..E9; done_o at E16.
- Speed scaling, PRESCALE=4, speed_i=2 → leds_o changes every 12 cycles. Changing speed_i mid-sweep leaves the period unchanged.
- Infinite run and stop, passes_i=0 → sweep continues past 16 passes with no done_o. stop_i at an arbitrary cycle → leds_o=0 and busy_o=0 on the next edge, no done_o.
- Contention: start_i and stop_i together in IDLE → stays IDLE. start_i pulsed while busy → sequence unaffected. passes_i=3 → exactly one done_o, 42 ticks after start (macro off).
